// File: rtl/f_fetch_unit.sv
// -----------------------------------------------------------------------------
// f_fetch_unit
//   Fetch-stage front end of the five-stage MIPS pipeline. It owns the F-stage
//   PC, issues in-order instruction-memory requests and tracks them in a
//   circular slot buffer. It presents {PC, instruction} pairs to the D stage.
//   It takes fetch-stream redirects from the D-stage next-PC logic.
//
// Parameters
//   RESET_PC  PC loaded on reset.
//   DEPTH     slot-buffer entries (power of two, 2..16).
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   redirect_valid  D stage requests a fetch-stream change
//   redirect_pc     new fetch address
//   imem_req        request valid (address = current F PC)
//   imem_addr       request address
//   imem_gnt        request accepted this cycle when imem_req=1
//   imem_rvalid     in-order response valid (at least one cycle after grant)
//   imem_rdata      instruction word
//   d_valid         head slot holds a filled instruction
//   d_ready         D stage accepts (0 = stall)
//   d_pc, d_instr   head slot PC and instruction
//   d_exc           head slot carries an address-error flag
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both 1 (imem_req/imem_gnt, d_valid/d_ready). valid never depends
//   combinationally on its own ready.
//
// Optional feature (macro FETCH_ALIGN_CHECK_EN):
//   defined   -> a misaligned redirect inserts one exception slot (exc=1,
//                instr=0) and halts fetching until the next redirect.
//   undefined -> redirect_pc[1:0] is forced to 0 and d_exc is tied to 0.
// -----------------------------------------------------------------------------
module f_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_exc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]       f_pc;
    logic [31:0]       slot_pc    [DEPTH];
    logic [31:0]       slot_instr [DEPTH];
    logic [DEPTH-1:0]  slot_filled;
    logic [PW-1:0]     alloc_ptr, fill_ptr, head_ptr;
    // alloc_count: allocated, not yet consumed. pend_count: granted, not yet
    // answered (and not flushed). drop_cnt: stale responses still to discard.
    logic [CW-1:0]     alloc_count, pend_count, drop_cnt;
    logic [CW:0]       credit_used;
    logic              credit_ok;
    logic              grant, resp_drop, resp_keep, consume;
    logic              fetch_block, exc_insert;
    logic [31:0]       redir_target;

    assign credit_used = {1'b0, alloc_count} + {1'b0, drop_cnt};
    assign credit_ok   = credit_used < (CW+1)'(DEPTH);

    // Request is never gated by imem_* inputs, so the stall path stays clean.
    assign imem_req  = reset && credit_ok && !redirect_valid && !fetch_block;
    assign imem_addr = f_pc;
    assign grant     = imem_req && imem_gnt;

    assign resp_drop = imem_rvalid && (drop_cnt != '0);
    assign resp_keep = imem_rvalid && (drop_cnt == '0) && (pend_count != '0);

    assign d_valid = slot_filled[head_ptr] && (alloc_count != '0);
    assign d_pc    = slot_pc[head_ptr];
    assign d_instr = slot_instr[head_ptr];
    assign consume = d_valid && d_ready;

`ifdef FETCH_ALIGN_CHECK_EN
    logic             exc_pending;   // misaligned redirect awaiting its slot
    logic             halted;        // exception slot issued, wait for redirect
    logic [DEPTH-1:0] slot_exc;
    logic             redir_misaligned;

    assign redir_target     = redirect_pc;
    assign redir_misaligned = |redirect_pc[1:0];
    assign fetch_block      = exc_pending || halted;
    assign exc_insert       = exc_pending && !redirect_valid;
    assign d_exc            = slot_exc[head_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_pending <= 1'b0;
            halted      <= 1'b0;
        end else if (redirect_valid) begin
            exc_pending <= redir_misaligned;
            halted      <= 1'b0;
        end else if (exc_insert) begin
            exc_pending <= 1'b0;
            halted      <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_exc <= '0;
        end else begin
            if (grant)
                slot_exc[alloc_ptr] <= 1'b0;
            if (exc_insert)
                slot_exc[alloc_ptr] <= 1'b1;
        end
    end
`else
    // Masking keeps every redirect_pc bit in use while forcing alignment.
    assign redir_target = redirect_pc & 32'hFFFF_FFFC;
    assign fetch_block  = 1'b0;
    assign exc_insert   = 1'b0;
    assign d_exc        = 1'b0;
`endif

    // PC, pointers and bookkeeping counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_pc        <= RESET_PC;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            alloc_count <= '0;
            pend_count  <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Any same-cycle consume has completed; flush everything else.
            // Requests still in flight become drops. A response kept this
            // cycle has answered its request and is not counted again.
            f_pc        <= redir_target;
            fill_ptr    <= alloc_ptr;
            head_ptr    <= alloc_ptr;
            alloc_count <= '0;
            pend_count  <= '0;
            drop_cnt    <= drop_cnt - CW'(resp_drop) + pend_count - CW'(resp_keep);
        end else begin
            if (grant)
                f_pc <= f_pc + 32'd4;
            if (grant || exc_insert)
                alloc_ptr <= alloc_ptr + PW'(1);
            if (resp_keep || exc_insert)
                fill_ptr <= fill_ptr + PW'(1);
            if (consume)
                head_ptr <= head_ptr + PW'(1);
            alloc_count <= alloc_count + CW'(grant || exc_insert) - CW'(consume);
            pend_count  <= pend_count + CW'(grant) - CW'(resp_keep);
            drop_cnt    <= drop_cnt - CW'(resp_drop);
        end
    end

    // Slot storage. Grant, fill and consume always touch distinct slots in a
    // given cycle, so the write order below never matters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc[i]    <= '0;
                slot_instr[i] <= '0;
            end
            slot_filled <= '0;
        end else begin
            if (consume)
                slot_filled[head_ptr] <= 1'b0;
            if (grant) begin
                slot_pc[alloc_ptr]     <= f_pc;
                slot_filled[alloc_ptr] <= 1'b0;
            end
            if (resp_keep && !redirect_valid) begin
                slot_instr[fill_ptr]  <= imem_rdata;
                slot_filled[fill_ptr] <= 1'b1;
            end
            if (exc_insert) begin
                slot_pc[alloc_ptr]     <= f_pc;
                slot_instr[alloc_ptr]  <= 32'h0000_0000;
                slot_filled[alloc_ptr] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_f_fetch_unit.sv
module tb_f_fetch_unit;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_exc;

    always #5 clk = ~clk;

    f_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .d_valid        (d_valid),
        .d_ready        (d_ready),
        .d_pc           (d_pc),
        .d_instr        (d_instr),
        .d_exc          (d_exc)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // ---------------- memory model ----------------
    // Decided on the falling edge for the next rising edge: the response for
    // the oldest due request, then capture of this cycle's grant.
    int          mem_lat = 1;
    int          cyc     = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    assign imem_gnt = 1'b1;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            mq_addr.delete();
            mq_due.delete();
            imem_rvalid = 1'b0;
        end else begin
            if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(mq_addr[0]);
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                imem_rvalid = 1'b0;
            end
            if (imem_req && imem_gnt) begin
                mq_addr.push_back(imem_addr);
                mq_due.push_back(cyc + mem_lat);
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (reset && d_valid && d_ready) begin
            got_pc.push_back(d_pc);
            got_instr.push_back(d_instr);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_stream(input string nm);
        foreach (exp_q[k]) begin
            if (got_pc.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s[%0d]: got nothing want pc %h", nm, k, exp_q[k]);
            end else begin
                check($sformatf("%s[%0d] pc", nm, k), got_pc.pop_front(), exp_q[k]);
                check($sformatf("%s[%0d] instr", nm, k), got_instr.pop_front(), instr_of(exp_q[k]));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 0 with reset released.
    task automatic reset_dut();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        d_ready        = 1'b0;
        step();
        step();
        got_pc.delete();
        got_instr.delete();
        reset = 1'b1;
    endtask

    task automatic chk(input string nm, input logic er, input logic [31:0] ea,
                       input logic edv, input logic [31:0] epc);
        @(negedge clk);
        check({nm, " req"}, 32'(imem_req), 32'(er));
        check({nm, " addr"}, imem_addr, ea);
        check({nm, " dvalid"}, 32'(d_valid), 32'(edv));
        if (edv)
            check({nm, " dpc"}, d_pc, epc);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        dv;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[23];

    initial begin
        // reset
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h3000, 1'b0, 32'h0};
        // zero-wait stream, d_ready=1
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h3004, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h3008, 1'b1, 32'h3000};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h300C, 1'b1, 32'h3004};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h3010, 1'b1, 32'h3008};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h3014, 1'b1, 32'h300C};
        // reset mid-stream
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h3000, 1'b0, 32'h0};
        // stall: 4 grants then full
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h3000, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h3004, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h3008, 1'b1, 32'h3000};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h300C, 1'b1, 32'h3000};
        for (int i = 12; i < 18; i++)
            vecs[i] = '{1'b1, 1'b0, 1'b0, 32'h3010, 1'b1, 32'h3000};
        // release
        vecs[18] = '{1'b1, 1'b1, 1'b0, 32'h3010, 1'b1, 32'h3000};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 32'h3010, 1'b1, 32'h3004};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 32'h3014, 1'b1, 32'h3008};
        vecs[21] = '{1'b1, 1'b1, 1'b1, 32'h3018, 1'b1, 32'h300C};
        vecs[22] = '{1'b1, 1'b1, 1'b1, 32'h301C, 1'b1, 32'h3010};

        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        d_ready        = 1'b0;
        step();

        for (int i = 0; i < 23; i++) begin
            reset   = vecs[i].rst_n;
            d_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("v%0d req", i), 32'(imem_req), 32'(vecs[i].req));
            check($sformatf("v%0d addr", i), imem_addr, vecs[i].addr);
            check($sformatf("v%0d dvalid", i), 32'(d_valid), 32'(vecs[i].dv));
            check($sformatf("v%0d dexc", i), 32'(d_exc), 32'h0);
            if (vecs[i].dv) begin
                check($sformatf("v%0d dpc", i), d_pc, vecs[i].pc);
                check($sformatf("v%0d dinstr", i), d_instr, instr_of(vecs[i].pc));
            end
            step();
        end

        // ---- redirect with two stale requests in flight, 3-cycle memory ----
        mem_lat = 3;
        reset_dut();
        d_ready = 1'b1;
        step();                                  // c1
        step();                                  // c2
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3400;
        chk("lat3 c2", 1'b0, 32'h3008, 1'b0, 32'h0);
        step();                                  // c3
        redirect_valid = 1'b0;
        chk("lat3 c3", 1'b1, 32'h3400, 1'b0, 32'h0);
        step(); step(); step();                  // c6
        chk("lat3 c6", imem_req, imem_addr, 1'b0, 32'h0);
        step();                                  // c7
        chk("lat3 c7", imem_req, imem_addr, 1'b1, 32'h3400);
        repeat (30) step();
        exp_q = '{32'h3400, 32'h3404, 32'h3408, 32'h340C};
        check_stream("lat3");
        mem_lat = 1;

        // ---- redirect in the same cycle as consuming 0x3008 ----
        reset_dut();
        d_ready = 1'b1;
        repeat (4) step();                       // c4
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3500;
        chk("rc c4", 1'b0, 32'h3010, 1'b1, 32'h3008);
        step();                                  // c5
        redirect_valid = 1'b0;
        chk("rc c5", 1'b1, 32'h3500, 1'b0, 32'h0);
        step();
        chk("rc c6", 1'b1, 32'h3504, 1'b0, 32'h0);
        step();
        chk("rc c7", 1'b1, 32'h3508, 1'b1, 32'h3500);
        repeat (6) step();
        exp_q = '{32'h3000, 32'h3004, 32'h3008, 32'h3500, 32'h3504, 32'h3508};
        check_stream("rc");

        // ---- redirect with kept response, then back-to-back redirects ----
        reset_dut();
        d_ready = 1'b1;
        repeat (3) step();                       // c3
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3100;
        step();                                  // c4
        redirect_pc    = 32'h3200;
        chk("b2b c4", 1'b0, 32'h3100, 1'b0, 32'h0);
        step();                                  // c5
        redirect_valid = 1'b0;
        chk("b2b c5", 1'b1, 32'h3200, 1'b0, 32'h0);
        step(); step();                          // c7
        chk("b2b c7", 1'b1, 32'h3208, 1'b1, 32'h3200);
        repeat (8) step();
        exp_q = '{32'h3000, 32'h3004, 32'h3200, 32'h3204, 32'h3208};
        check_stream("b2b");

        // ---- misaligned redirect ----
        reset_dut();
        d_ready        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3402;
        step();                                  // c1
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("al c1", 1'b0, 32'h3402, 1'b0, 32'h0);
        step();                                  // c2
        chk("al c2", 1'b0, 32'h3402, 1'b1, 32'h3402);
        check("al c2 dexc", 32'(d_exc), 32'h1);
        check("al c2 dinstr", d_instr, 32'h0);
        step();
        chk("al c3", 1'b0, 32'h3402, 1'b0, 32'h0);
        step();                                  // c4
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4180;
        chk("al c4", 1'b0, 32'h3402, 1'b0, 32'h0);
        step();                                  // c5
        redirect_valid = 1'b0;
        chk("al c5", 1'b1, 32'h4180, 1'b0, 32'h0);
`else
        chk("al c1", 1'b1, 32'h3400, 1'b0, 32'h0);
        step(); step();                          // c3
        chk("al c3", 1'b1, 32'h3408, 1'b1, 32'h3400);
        check("al c3 dexc", 32'(d_exc), 32'h0);
        check("al c3 dinstr", d_instr, instr_of(32'h3400));
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
